// File: rtl/timer_pkg.sv
// Shared definitions for the timer interrupt front-end: FSM state encoding
// and channel numbering used by timer_irq_ctrl and its sub-modules.
package timer_pkg;

  localparam int NUM_TIMER_CH = 2;
  localparam int CH0          = 0;
  localparam int CH1          = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    HOLDOFF = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_pending_bit.sv
// One interrupt channel: a sticky pending flop with W1C clear and an
// optional saturating counter of events that arrived while already pending.
// Optional feature macro: TIMER_IRQ_MISS_CNT_EN (miss counter present).
module irq_pending_bit
  import timer_pkg::*;
#(
  parameter int MISS_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done,
  input  logic              clr,
  output logic              pending,
  output logic [MISS_W-1:0] miss_cnt
);

  // Pending flop: a new event beats a simultaneous clear so nothing is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
    end else if (done) begin
      pending <= 1'b1;
    end else if (clr) begin
      pending <= 1'b0;
    end
  end

`ifdef TIMER_IRQ_MISS_CNT_EN
  // Miss counter: cleared with its pending bit, otherwise counts repeat events up to all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_cnt <= '0;
    end else if (clr) begin
      miss_cnt <= '0;
    end else if (done && pending && (miss_cnt != {MISS_W{1'b1}})) begin
      miss_cnt <= miss_cnt + MISS_W'(1);
    end
  end
`else
  assign miss_cnt = '0;
`endif

endmodule

// File: rtl/timer_irq_ctrl.sv
// Interrupt front-end for the AXI4-lite timer: latches both channel done
// pulses into pending bits, masks them, and drives one level interrupt with
// a programmable quiet period after each service.
// Optional feature macro: TIMER_IRQ_MISS_CNT_EN (per-channel miss counters).
module timer_irq_ctrl
  import timer_pkg::*;
#(
  parameter int MISS_W    = 8,
  parameter int HOLDOFF_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_cnt0_done,
  input  logic                 i_cnt1_done,
  input  logic [1:0]           i_irq_mask,
  input  logic [HOLDOFF_W-1:0] i_holdoff,
  input  logic                 i_clr_valid,
  input  logic [1:0]           i_clr_mask,
  output logic [1:0]           o_irq_pending,
  output logic [MISS_W-1:0]    o_miss_cnt0,
  output logic [MISS_W-1:0]    o_miss_cnt1,
  output logic                 o_irq
);

  logic [NUM_TIMER_CH-1:0] done_vec;
  logic [NUM_TIMER_CH-1:0] clr_vec;
  logic                    act;
  irq_state_e              state_q;
  irq_state_e              state_d;
  logic [HOLDOFF_W-1:0]    hold_q;
  logic [HOLDOFF_W-1:0]    hold_d;

  assign done_vec = {i_cnt1_done, i_cnt0_done};
  assign clr_vec  = i_clr_valid ? i_clr_mask : '0;

  irq_pending_bit #(.MISS_W(MISS_W)) u_ch0 (
    .clk      (clk),
    .rst      (rst),
    .done     (done_vec[CH0]),
    .clr      (clr_vec[CH0]),
    .pending  (o_irq_pending[CH0]),
    .miss_cnt (o_miss_cnt0)
  );

  irq_pending_bit #(.MISS_W(MISS_W)) u_ch1 (
    .clk      (clk),
    .rst      (rst),
    .done     (done_vec[CH1]),
    .clr      (clr_vec[CH1]),
    .pending  (o_irq_pending[CH1]),
    .miss_cnt (o_miss_cnt1)
  );

  assign act   = |(o_irq_pending & i_irq_mask);
  assign o_irq = (state_q == ACTIVE);

  // State and hold-off counter registers; reset abandons any quiet period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state: raise on any enabled pending bit, then sit quiet for i_holdoff cycles after it drops.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (act) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (!act) begin
          if (i_holdoff == '0) begin
            state_d = IDLE;
          end else begin
            state_d = HOLDOFF;
            hold_d  = i_holdoff;
          end
        end
      end
      HOLDOFF: begin
        if (hold_q <= HOLDOFF_W'(1)) begin
          state_d = IDLE;
          hold_d  = '0;
        end else begin
          hold_d = hold_q - HOLDOFF_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Self-checking bench for timer_irq_ctrl: directed scenarios followed by
// random traffic, all compared against a cycle-level behavioural model.
module tb_timer_irq_ctrl;

  localparam int MISS_W    = 8;
  localparam int HOLDOFF_W = 16;
  localparam int MISS_MAX  = (1 << MISS_W) - 1;
`ifdef TIMER_IRQ_MISS_CNT_EN
  localparam int SAT_EXP = MISS_MAX;
`else
  localparam int SAT_EXP = 0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 i_cnt0_done;
  logic                 i_cnt1_done;
  logic [1:0]           i_irq_mask;
  logic [HOLDOFF_W-1:0] i_holdoff;
  logic                 i_clr_valid;
  logic [1:0]           i_clr_mask;
  logic [1:0]           o_irq_pending;
  logic [MISS_W-1:0]    o_miss_cnt0;
  logic [MISS_W-1:0]    o_miss_cnt1;
  logic                 o_irq;

  int checks   = 0;
  int failures = 0;

  // Reference model state: pending flags, miss tallies, interrupt level and
  // the number of quiet cycles still owed after the line last dropped.
  bit [1:0] m_pend;
  int       m_miss [2];
  bit       m_irq;
  int       m_quiet;

  always #5 clk = ~clk;

  timer_irq_ctrl #(.MISS_W(MISS_W), .HOLDOFF_W(HOLDOFF_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_cnt0_done   (i_cnt0_done),
    .i_cnt1_done   (i_cnt1_done),
    .i_irq_mask    (i_irq_mask),
    .i_holdoff     (i_holdoff),
    .i_clr_valid   (i_clr_valid),
    .i_clr_mask    (i_clr_mask),
    .o_irq_pending (o_irq_pending),
    .o_miss_cnt0   (o_miss_cnt0),
    .o_miss_cnt1   (o_miss_cnt1),
    .o_irq         (o_irq)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int expMiss(input int ch);
`ifdef TIMER_IRQ_MISS_CNT_EN
    return m_miss[ch];
`else
    return 0;
`endif
  endfunction

  task automatic modelReset();
    m_pend    = 2'b00;
    m_miss[0] = 0;
    m_miss[1] = 0;
    m_irq     = 1'b0;
    m_quiet   = 0;
  endtask

  // One clock edge of the model, using the pre-edge pending flags.
  task automatic modelEdge(input bit d0, input bit d1, input bit cv, input bit [1:0] cm);
    bit       act;
    bit [1:0] done;
    bit [1:0] clr;
    act  = |(m_pend & i_irq_mask);
    done = {d1, d0};
    clr  = cv ? cm : 2'b00;
    if (m_irq) begin
      if (!act) begin
        m_irq   = 1'b0;
        m_quiet = int'(i_holdoff);
      end
    end else if (m_quiet > 0) begin
      m_quiet--;
    end else if (act) begin
      m_irq = 1'b1;
    end
    for (int ch = 0; ch < 2; ch++) begin
      if (clr[ch]) m_miss[ch] = 0;
      else if (done[ch] && m_pend[ch] && m_miss[ch] < MISS_MAX) m_miss[ch]++;
      if (done[ch]) m_pend[ch] = 1'b1;
      else if (clr[ch]) m_pend[ch] = 1'b0;
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_pending"}, 32'(o_irq_pending), 32'(m_pend));
    checkOutput({tag, "_miss0"}, 32'(o_miss_cnt0), 32'(expMiss(0)));
    checkOutput({tag, "_miss1"}, 32'(o_miss_cnt1), 32'(expMiss(1)));
    checkOutput({tag, "_irq"}, 32'(o_irq), 32'(m_irq));
  endtask

  // Drive one cycle of inputs, advance the model on the edge, check just after it.
  task automatic applyStimulus(input bit d0, input bit d1, input bit cv, input bit [1:0] cm);
    i_cnt0_done = d0;
    i_cnt1_done = d1;
    i_clr_valid = cv;
    i_clr_mask  = cm;
    @(posedge clk);
    if (rst) modelReset();
    else modelEdge(d0, d1, cv, cm);
    #1;
    i_cnt0_done = 1'b0;
    i_cnt1_done = 1'b0;
    i_clr_valid = 1'b0;
    i_clr_mask  = 2'b00;
    checkAll("cyc");
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  initial begin
    int low;
    rst         = 1'b1;
    i_cnt0_done = 1'b0;
    i_cnt1_done = 1'b0;
    i_irq_mask  = 2'b00;
    i_holdoff   = '0;
    i_clr_valid = 1'b0;
    i_clr_mask  = 2'b00;
    modelReset();

    // Reset state, observed before the first clock edge.
    #3;
    checkOutput("rst_pending", 32'(o_irq_pending), 32'd0);
    checkOutput("rst_irq", 32'(o_irq), 32'd0);
    checkOutput("rst_miss0", 32'(o_miss_cnt0), 32'd0);
    idleCycles(2);
    rst = 1'b0;
    idleCycles(7);

    // Latency: pulse to pending one edge, pending to irq one more.
    $display("[TB] latency");
    i_irq_mask = 2'b01;
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
    checkOutput("lat_pend_e0", 32'(o_irq_pending), 32'd1);
    checkOutput("lat_irq_e0", 32'(o_irq), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00);
    checkOutput("lat_irq_e1", 32'(o_irq), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b01);
    checkOutput("clr_pend_ek", 32'(o_irq_pending), 32'd0);
    checkOutput("clr_irq_ek", 32'(o_irq), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00);
    checkOutput("clr_irq_ek1", 32'(o_irq), 32'd0);
    idleCycles(2);

    // Masked channel still latches but never raises the line.
    $display("[TB] masked event");
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b00);
      checkOutput("mask_irq", 32'(o_irq), 32'd0);
    end
    checkOutput("mask_pend", 32'(o_irq_pending), 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b10);

    // Set/clear collision: the event survives and the miss count restarts at 0.
    $display("[TB] collision");
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b01);
    checkOutput("coll_pend0", 32'(o_irq_pending[0]), 32'd1);
    checkOutput("coll_miss0", 32'(o_miss_cnt0), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b01);
    idleCycles(3);

    // Miss counter saturation.
    $display("[TB] saturation");
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
    for (int k = 0; k < 300; k++) applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
    checkOutput("sat_miss0", 32'(o_miss_cnt0), 32'(SAT_EXP));
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b01);
    checkOutput("sat_clr_miss0", 32'(o_miss_cnt0), 32'd0);
    idleCycles(3);

    // Hold-off coalescing with both channels enabled.
    $display("[TB] holdoff");
    i_irq_mask = 2'b11;
    i_holdoff  = HOLDOFF_W'(5);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b00);
    idleCycles(2);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b01);
    idleCycles(2);
    checkOutput("ho_irq_ch1_held", 32'(o_irq), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b10);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
    low = (o_irq == 1'b0) ? 1 : 0;
    for (int k = 0; k < 20; k++) begin
      if (o_irq) break;
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b00);
      if (!o_irq) low++;
    end
    checkOutput("ho_low_cycles", 32'(low), 32'd6);
    checkOutput("ho_reassert", 32'(o_irq), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b11);

    // Asynchronous reset in the middle of a long hold-off.
    $display("[TB] reset mid-holdoff");
    i_irq_mask = 2'b01;
    i_holdoff  = HOLDOFF_W'(100);
    idleCycles(3);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
    idleCycles(2);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b01);
    idleCycles(3);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00);
    idleCycles(2);
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("arst_pending", 32'(o_irq_pending), 32'd0);
    checkOutput("arst_miss0", 32'(o_miss_cnt0), 32'd0);
    checkOutput("arst_irq", 32'(o_irq), 32'd0);
    idleCycles(2);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00);
    checkOutput("arst_fsm_idle", 32'(o_irq), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b11);

    // Random traffic against the model.
    $display("[TB] random");
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 31) == 0) i_irq_mask = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) i_holdoff = HOLDOFF_W'($urandom_range(0, 6));
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 4) == 0, 2'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_irq_ctrl.md
Name: timer_irq_ctrl

Overview:
- Interrupt front-end for the AXI4-lite timer. Consumes the single-cycle done pulses from both timer/counter channels.
- Latches each pulse into a pending bit and applies a per-channel enable mask.
- Drives one level interrupt line with programmable hold-off coalescing.
- Register-side logic reads pending status and clears it write-1-to-clear (W1C).

Parameters:
- MISS_W, 8, width of each per-channel saturating missed-event counter.
- HOLDOFF_W, 16, width of the hold-off cycle count input and its internal counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high; clears all state immediately.
- i_cnt0_done  in  1  channel 0 done pulse, one cycle wide.
- i_cnt1_done  in  1  channel 1 done pulse, one cycle wide.
- i_irq_mask  in  2  per-channel interrupt enable; bit0 = ch0, bit1 = ch1.
- i_holdoff  in  HOLDOFF_W  quiet cycles forced after the interrupt is serviced.
- i_clr_valid  in  1  W1C strobe from the register block.
- i_clr_mask  in  2  pending bits to clear when i_clr_valid = 1.
- o_irq_pending  out  2  raw latched pending bits. Not masked.
- o_miss_cnt0  out  MISS_W  ch0 events that arrived while already pending.
- o_miss_cnt1  out  MISS_W  ch1 events that arrived while already pending.
- o_irq  out  1  level interrupt to the CPU.

Behaviour:
- Reset (async, rst = 1):
  - o_irq_pending = 0, both miss counters = 0, FSM = IDLE, hold-off counter = 0, o_irq = 0.
  - Reset mid-operation aborts any hold-off. Counts are lost.
- Pending bit n, per edge, in priority order:
  - If done_n = 1, pending_n <= 1. Set wins over a simultaneous clear, so no event is lost.
  - Otherwise, if i_clr_valid and i_clr_mask[n], pending_n <= 0.
  - Otherwise, pending_n holds.
- The mask never gates latching. Masked events still set pending and remain pollable.
- Miss counter n:
  - Increments by 1 when done_n = 1, pending_n = 1, and it is not being cleared that same cycle.
  - Saturates at 2^MISS_W-1. No wrap.
  - Cleared together with pending_n: i_clr_valid and i_clr_mask[n] with no simultaneous done_n.
  - If done_n and the clear coincide, the counter is cleared to 0 (the event is counted as pending, not missed).
- Definition: act = |(o_irq_pending & i_irq_mask), evaluated on registered pending.
- FSM states (registered): IDLE, ACTIVE, HOLDOFF. o_irq = (state == ACTIVE), decoded from the state register only.
  - IDLE: if act, go to ACTIVE.
  - ACTIVE: if !act, then if i_holdoff == 0 go to IDLE; otherwise load the counter with i_holdoff and go to HOLDOFF.
  - HOLDOFF: decrement the counter each cycle. When the counter is 1, go to IDLE. New events latch but o_irq stays 0. Mask changes do not shorten hold-off.
- Latency:
  - Done pulse sampled at edge E0 sets pending after E0. With act, state = ACTIVE and o_irq = 1 after E1, i.e. 2 cycles from pulse to irq.
  - Clear at edge Ek drops pending. o_irq falls after Ek+1.
  - HOLDOFF occupies exactly i_holdoff cycles. With act still true, the earliest re-assert is i_holdoff+1 cycles after o_irq falls.
- Mask cleared while ACTIVE: act = 0, so the ACTIVE exit rules apply (IDLE or HOLDOFF).
- Back-to-back pulses on the same channel: the first sets pending, each later pulse increments the miss counter.

Optional Feature:
- Macro TIMER_IRQ_MISS_CNT_EN.
- Defined: miss counters implemented as described.
- Undefined: no counter flops; o_miss_cnt0 and o_miss_cnt1 are tied to 0. Pending and FSM behaviour are unchanged.

Decomposition:
- Shared package timer_pkg holds:
  - the irq_state_e enum (IDLE, ACTIVE, HOLDOFF);
  - the channel count constant NUM_TIMER_CH = 2;
  - the channel index constants CH0 = 0, CH1 = 1.
- One natural sub-module: irq_pending_bit. It holds one pending flop plus its miss counter and is instantiated per channel.
- The FSM and the hold-off counter stay in the top module.

Test Plan:
- Reset: assert rst mid-HOLDOFF with i_holdoff = 100 -> all outputs 0 immediately, no clock edge needed. FSM returns to IDLE.
- Latency: mask = 2'b01, single i_cnt0_done pulse at cycle 10 -> o_irq_pending = 2'b01 from cycle 11, o_irq = 1 from cycle 12.
- Masked event: mask = 2'b01, i_cnt1_done pulse -> o_irq_pending = 2'b10, o_irq stays 0 for 20 cycles.
- Set/clear collision: ch0 pending; i_clr_valid with i_clr_mask = 2'b01 in the same cycle as i_cnt0_done -> pending_0 stays 1, o_miss_cnt0 = 0.
- Miss saturation: ch0 pending, 300 further done pulses with MISS_W = 8 and macro defined -> o_miss_cnt0 = 255. Without the macro -> 0.
- Hold-off: i_holdoff = 5, ch0 and ch1 enabled:
  - clear ch0 while ch1 is pending -> o_irq stays 1;
  - then clear ch1 and re-pulse ch0 immediately -> o_irq low for exactly 6 cycles, then 1.
